psram_tx_fetch: RTL and testbench



---
 rtl/psram_pkg.sv | 14 +
 rtl/psram_tx_fetch_if.sv | 39 +++
 rtl/psram_fetch_fifo.sv | 50 +++++
 rtl/psram_tx_fetch.sv | 124 ++++++++++++
 tb/tb_psram_tx_fetch.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM write-path fetch logic: data width,
// default address/length widths and the fetch engine state encoding.
package psram_pkg;

    localparam int PSRAM_DW = 32;
    localparam int PSRAM_AW = 10;
    localparam int PSRAM_LW = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/psram_tx_fetch_if.sv
// Bus bundle between the fetch engine, the SRAM write buffer (read port)
// and the downstream PSRAM TX buffer (word request/ack handshake).
interface psram_tx_fetch_if
    import psram_pkg::*;
#(
    parameter int AW = PSRAM_AW
);

    // Downstream TX buffer handshake
    logic                ram_rd_req;
    logic                ram_rd_ack;
    logic [PSRAM_DW-1:0] ram_rdata;

    // SRAM write-buffer read port
    logic                sram_cs;
    logic [AW-1:0]       sram_addr;
    logic [PSRAM_DW-1:0] sram_rdata;

    // Fetch engine side
    modport master (
        input  ram_rd_req,
        input  sram_rdata,
        output ram_rd_ack,
        output ram_rdata,
        output sram_cs,
        output sram_addr
    );

    // Environment side (TX buffer plus SRAM)
    modport slave (
        output ram_rd_req,
        output sram_rdata,
        input  ram_rd_ack,
        input  ram_rdata,
        input  sram_cs,
        input  sram_addr
    );

endinterface

// File: rtl/psram_fetch_fifo.sv
// Two-entry prefetch queue. Flush wins over push; the caller never pops
// an empty queue or pushes a full one.
module psram_fetch_fifo
    import psram_pkg::*;
(
    input  logic                hclk,
    input  logic                hrstn,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [PSRAM_DW-1:0] wdata,
    output logic [PSRAM_DW-1:0] rdata,
    output logic [1:0]          occ
);

    logic [PSRAM_DW-1:0] mem [2];
    logic                wr_ptr;
    logic                rd_ptr;

    // Storage write.
    // NOTE: the data array has no reset; its contents are never observed
    // while the queue is empty, so only pointers and count need one.
    always_ff @(posedge hclk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/psram_tx_fetch.sv
// Write-path fetch engine: on start, reads len words from the SRAM write
// buffer starting at base_addr and hands them to the PSRAM TX buffer
// through a 2-entry prefetch queue. A word returning from SRAM may be
// handed over in the same cycle it arrives, so it counts as queued
// occupancy from that cycle on.
module psram_tx_fetch
    import psram_pkg::*;
#(
    parameter int AW = PSRAM_AW,
    parameter int LW = PSRAM_LW
)
(
    input  logic          hclk,
    input  logic          hrstn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    psram_tx_fetch_if.master bus
);

    fetch_state_e        state;
    fetch_state_e        state_d;
    logic                done_d;

    logic [LW-1:0]       issue_cnt;
    logic [LW-1:0]       deliv_cnt;
    logic [LW-1:0]       len_r;
    logic [AW-1:0]       base_r;
    logic                capture;     // SRAM data lands this cycle

    logic                issue;
    logic                pop;
    logic                last_pop;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_empty;
    logic [1:0]          occ;
    logic [2:0]          level;
    logic [PSRAM_DW-1:0] head;

    psram_fetch_fifo u_fifo (
        .hclk  (hclk),
        .hrstn (hrstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (start),
        .wdata (bus.sram_rdata),
        .rdata (head),
        .occ   (occ)
    );

    assign busy       = (state == RUN);
    assign fifo_empty = (occ == 2'd0);

    // A word is available if queued or arriving from SRAM right now.
    assign bus.ram_rd_ack = busy & bus.ram_rd_req & (~fifo_empty | capture);
    assign pop            = bus.ram_rd_req & bus.ram_rd_ack;
    assign bus.ram_rdata  = !fifo_empty ? head :
                            (capture ? bus.sram_rdata : '0);

    // Arriving word consumed directly is not stored; otherwise it is queued.
    assign fifo_push = capture & ~(pop & fifo_empty);
    assign fifo_pop  = pop & ~fifo_empty;

    // Queue level after this cycle's arrival and departure bounds issue.
    assign level         = {1'b0, occ} + {2'b0, capture} - {2'b0, pop};
    assign issue         = busy & (issue_cnt < len_r) & (level < 3'd2);
    assign bus.sram_cs   = issue;
    assign bus.sram_addr = base_r + AW'(issue_cnt);

    assign last_pop = pop & ((deliv_cnt + LW'(1)) == len_r);

    // State register.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and completion pulse; start overrides everything.
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        if (start) begin
            state_d = (len != '0) ? RUN : IDLE;
            done_d  = (len == '0);
        end else if (busy && last_pop) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    // Transfer bookkeeping: counters, sampled parameters, in-flight flag.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            issue_cnt <= '0;
            deliv_cnt <= '0;
            len_r     <= '0;
            base_r    <= '0;
            capture   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= done_d;
            // A read issued in a start cycle belongs to the aborted transfer.
            capture <= issue & ~start;
            if (start) begin
                issue_cnt <= '0;
                deliv_cnt <= '0;
                len_r     <= len;
                base_r    <= base_addr;
            end else begin
                if (issue) issue_cnt <= issue_cnt + LW'(1);
                if (pop)   deliv_cnt <= deliv_cnt + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_psram_tx_fetch.sv
// Directed bench for psram_tx_fetch. Expected words (and, where fixed,
// their cycle relative to the start edge) are queued at stimulus time;
// a negedge monitor pops and compares on every handshake.
module tb_psram_tx_fetch;
    import psram_pkg::*;

    logic        hclk  = 1'b0;
    logic        hrstn = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] len = '0;
    logic        busy;
    logic        done;

    psram_tx_fetch_if #(.AW(10)) bus ();

    psram_tx_fetch #(.AW(10), .LW(11)) dut (
        .hclk      (hclk),
        .hrstn     (hrstn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 hclk = ~hclk;

    // SRAM model: word = address, one cycle read latency.
    always @(posedge hclk) begin
        if (bus.sram_cs) bus.sram_rdata <= 32'(bus.sram_addr);
    end

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;   // -1: any cycle
    } exp_t;

    exp_t       exp_q [$];
    logic [9:0] addr_log [$];
    int n_vec = 0;
    int n_err = 0;
    int t_start = 0;
    int ack_cnt, cs_cnt, done_cnt, done_rel, last_ack_rel;
    int issued, popped, max_ahead;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: handshakes, issues, completion pulses.
    always @(negedge hclk) begin
        int   rel;
        exp_t e;
        if (hrstn) begin
            rel = cyc - t_start + 1;
            if (bus.sram_cs) begin
                cs_cnt++;
                issued++;
                addr_log.push_back(bus.sram_addr);
            end
            if (bus.ram_rd_req && bus.ram_rd_ack) begin
                ack_cnt++;
                popped++;
                last_ack_rel = rel;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got data 0x%0h at cycle %0d, want no ack",
                             bus.ram_rdata, rel);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_data", bus.ram_rdata, e.data);
                    if (e.cyc >= 0) check("ack_cycle", 32'(rel), 32'(e.cyc));
                end
            end
            if (issued - popped > max_ahead) max_ahead = issued - popped;
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
        end
    end

    task automatic clear_stats();
        ack_cnt = 0; cs_cnt = 0; done_cnt = 0; done_rel = -1; last_ack_rel = -1;
        issued = 0; popped = 0; max_ahead = 0;
        addr_log.delete();
    endtask

    task automatic expect_word(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    // Start pulse is driven in cycle 0 and sampled at edge 0.
    task automatic start_xfer(input logic [9:0] b, input logic [10:0] l);
        start = 1'b1;
        base_addr = b;
        len = l;
        @(posedge hclk);
        #1;
        start = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_done(input int max, input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < max) begin
            idle(1);
            k++;
        end
        if (done_cnt == d0) check(name, 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic wait_acks(input int n, input int max, input string name);
        int k;
        k = 0;
        while (ack_cnt < n && k < max) begin
            idle(1);
            k++;
        end
        if (ack_cnt < n) check(name, 32'(ack_cnt), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
        $fatal(1);
    end

    initial begin
        logic [9:0] wrap_exp [4];
        int a0;
        wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF;
        wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
        bus.ram_rd_req = 1'b0;
        clear_stats();

        // Reset values
        #12;
        check("rst_ack",   32'(bus.ram_rd_ack), 32'h0);
        check("rst_rdata", bus.ram_rdata,       32'h0);
        check("rst_cs",    32'(bus.sram_cs),    32'h0);
        check("rst_addr",  32'(bus.sram_addr),  32'h0);
        check("rst_busy",  32'(busy),           32'h0);
        check("rst_done",  32'(done),           32'h0);
        @(negedge hclk);
        hrstn = 1'b1;
        idle(2);

        // Basic transfer
        clear_stats();
        bus.ram_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) expect_word(32'h010 + 32'(i), 2 + i);
        start_xfer(10'h010, 11'd4);
        wait_done(40, "basic_timeout");
        check("basic_done_cycle", 32'(done_rel), 32'd6);
        check("basic_cs_count",   32'(cs_cnt),   32'd4);
        check("basic_ack_count",  32'(ack_cnt),  32'd4);
        bus.ram_rd_req = 1'b0;
        idle(2);
        check("basic_done_count", 32'(done_cnt), 32'd1);

        // Back-pressure: request one cycle in three
        clear_stats();
        for (int i = 0; i < 6; i++) expect_word(32'h040 + 32'(i), -1);
        start_xfer(10'h040, 11'd6);
        for (int k = 0; k < 90 && done_cnt == 0; k++) begin
            bus.ram_rd_req = (k % 3 == 2);
            idle(1);
        end
        bus.ram_rd_req = 1'b0;
        if (done_cnt == 0) check("bp_timeout", 32'(done_cnt), 32'd1);
        idle(2);
        check("bp_ack_count",  32'(ack_cnt),   32'd6);
        check("bp_max_ahead",  32'(max_ahead), 32'd2);
        check("bp_done_after", 32'(done_rel),  32'(last_ack_rel + 1));
        check("bp_done_count", 32'(done_cnt),  32'd1);

        // Address wrap
        clear_stats();
        bus.ram_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) expect_word(32'(wrap_exp[i]), 2 + i);
        start_xfer(10'h3FE, 11'd4);
        wait_done(40, "wrap_timeout");
        check("wrap_addr_count", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check("wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));
        bus.ram_rd_req = 1'b0;
        idle(2);

        // Zero length with request held high
        clear_stats();
        bus.ram_rd_req = 1'b1;
        start_xfer(10'h055, 11'd0);
        idle(4);
        check("zero_done_count", 32'(done_cnt), 32'd1);
        check("zero_done_cycle", 32'(done_rel), 32'd1);
        check("zero_cs_count",   32'(cs_cnt),   32'd0);
        check("zero_ack_count",  32'(ack_cnt),  32'd0);

        // One word, ten cycles of over-request
        clear_stats();
        expect_word(32'h077, 2);
        start_xfer(10'h077, 11'd1);
        idle(10);
        bus.ram_rd_req = 1'b0;
        check("one_ack_count",  32'(ack_cnt),  32'd1);
        check("one_cs_count",   32'(cs_cnt),   32'd1);
        check("one_done_count", 32'(done_cnt), 32'd1);
        check("one_done_cycle", 32'(done_rel), 32'd3);
        idle(2);

        // Restart mid-transfer
        clear_stats();
        bus.ram_rd_req = 1'b1;
        for (int i = 0; i < 3; i++) expect_word(32'h100 + 32'(i), 2 + i);
        start_xfer(10'h100, 11'd8);
        wait_acks(3, 40, "restart_ack_timeout");
        bus.ram_rd_req = 1'b0;
        expect_word(32'h200, 2);
        expect_word(32'h201, 3);
        start_xfer(10'h200, 11'd2);
        bus.ram_rd_req = 1'b1;
        wait_done(40, "restart_timeout");
        bus.ram_rd_req = 1'b0;
        idle(3);
        check("restart_done_count", 32'(done_cnt), 32'd1);
        check("restart_done_cycle", 32'(done_rel), 32'd4);
        check("restart_ack_count",  32'(ack_cnt),  32'd5);

        // Asynchronous reset mid-transfer
        clear_stats();
        bus.ram_rd_req = 1'b1;
        for (int i = 0; i < 8; i++) expect_word(32'h300 + 32'(i), -1);
        start_xfer(10'h300, 11'd8);
        wait_acks(2, 40, "arst_ack_timeout");
        @(negedge hclk);
        #2;
        hrstn = 1'b0;
        #1;
        a0 = ack_cnt;
        exp_q.delete();
        check("arst_ack",   32'(bus.ram_rd_ack), 32'h0);
        check("arst_rdata", bus.ram_rdata,       32'h0);
        check("arst_cs",    32'(bus.sram_cs),    32'h0);
        check("arst_addr",  32'(bus.sram_addr),  32'h0);
        check("arst_busy",  32'(busy),           32'h0);
        check("arst_done",  32'(done),           32'h0);
        #10;
        hrstn = 1'b1;
        idle(6);
        check("arst_no_ack",  32'(ack_cnt),  32'(a0));
        check("arst_no_done", 32'(done_cnt), 32'd0);

        // Recovery after reset
        clear_stats();
        expect_word(32'h020, 2);
        expect_word(32'h021, 3);
        start_xfer(10'h020, 11'd2);
        wait_done(40, "recover_timeout");
        bus.ram_rd_req = 1'b0;
        check("recover_done_cycle", 32'(done_rel), 32'd4);
        idle(2);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
